// File: rtl/sort_pkg.sv
// Shared types and helpers for the bitonic sort batch controller.
// sort_latency gives the pipeline depth of a bitonic sorter of 2**depth lanes.
package sort_pkg;

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} sort_ctrl_state_t;

  function automatic int sort_latency(input int depth);
    return depth * (depth + 1) / 2;
  endfunction

endpackage

// File: rtl/sort_batch_ctrl.sv
// Serial-to-parallel batch sequencer around a pipelined bitonic sorter: fill, wait LATENCY+1, drain.
// Optional short-batch padding with s_last is enabled by defining SORT_BATCH_CTRL_PAD_EN.
module sort_batch_ctrl
  import sort_pkg::*;
#(
  parameter int VALUE_BITS = 8,
  parameter int DEPTH      = 4,
  parameter int LATENCY    = sort_latency(DEPTH)
`ifdef SORT_BATCH_CTRL_PAD_EN
  , parameter logic [VALUE_BITS-1:0] PAD_VALUE = '1
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [VALUE_BITS-1:0]               s_data,
`ifdef SORT_BATCH_CTRL_PAD_EN
  input  logic                                s_last,
`endif
  output logic [(1<<DEPTH)*VALUE_BITS-1:0]    sort_in,
  input  logic [(1<<DEPTH)*VALUE_BITS-1:0]    sort_out,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [VALUE_BITS-1:0]               m_data,
  output logic                                m_last,
  output logic                                busy
);

  localparam int SIZE = 1 << DEPTH;
  localparam int CW   = DEPTH + 1;
  localparam int WW   = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(SIZE - 1);
  localparam logic [WW-1:0] WAIT_END  = WW'(LATENCY);

  sort_ctrl_state_t r_state, w_state_nxt;

  logic [SIZE-1:0][VALUE_BITS-1:0] r_ibuf;
  logic [SIZE-1:0][VALUE_BITS-1:0] r_obuf;
  logic [CW-1:0]                   r_cnt;
  logic [CW-1:0]                   r_idx;
  logic [WW-1:0]                   r_wcnt;
  logic [CW-1:0]                   w_last_idx;
  logic                            w_fill_done;
  logic                            w_wait_done;

`ifdef SORT_BATCH_CTRL_PAD_EN
  logic [CW-1:0] r_nvalid;
  assign w_last_idx  = r_nvalid - CW'(1);
  assign w_fill_done = s_valid && ((r_cnt == LAST_SLOT) || s_last);
`else
  assign w_last_idx  = LAST_SLOT;
  assign w_fill_done = s_valid && (r_cnt == LAST_SLOT);
`endif

  assign w_wait_done = (r_wcnt == WAIT_END);
  assign sort_in     = r_ibuf;
  assign m_data      = r_obuf[r_idx[DEPTH-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_state_nxt;
  end

  // Handshake flags depend on registered state only; inputs affect next state alone.
  always_comb begin
    w_state_nxt = r_state;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    busy        = 1'b1;
    case (r_state)
      FILL: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (w_fill_done) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (w_wait_done) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        m_valid = 1'b1;
        m_last  = (r_idx == w_last_idx);
        if (m_ready && (r_idx == w_last_idx)) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ibuf   <= '0;
      r_obuf   <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_wcnt   <= '0;
`ifdef SORT_BATCH_CTRL_PAD_EN
      r_nvalid <= CW'(SIZE);
`endif
    end else begin
      case (r_state)
        FILL: begin
          if (s_valid) begin
            r_ibuf[r_cnt[DEPTH-1:0]] <= s_data;
            if (w_fill_done) begin
              r_cnt  <= '0;
              r_wcnt <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
`ifdef SORT_BATCH_CTRL_PAD_EN
            // Pads land above the last real value so an ascending sort pushes them past nvalid.
            if (s_last) begin
              for (int i = 0; i < SIZE; i++) begin
                if (i > int'(r_cnt)) r_ibuf[i] <= PAD_VALUE;
              end
              r_nvalid <= r_cnt + CW'(1);
            end else if (r_cnt == LAST_SLOT) begin
              r_nvalid <= CW'(SIZE);
            end
`endif
          end
        end
        WAIT: begin
          r_wcnt <= r_wcnt + WW'(1);
          if (w_wait_done) begin
            r_obuf <= sort_out;
            r_idx  <= '0;
          end
        end
        DRAIN: begin
          if (m_ready) r_idx <= r_idx + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_batch_ctrl.sv
// Scoreboard bench for sort_batch_ctrl paired with a 10-stage behavioural ascending sorter.
// Pad test is compiled only when SORT_BATCH_CTRL_PAD_EN is defined.
module tb_sort_batch_ctrl;

  typedef logic [15:0][7:0] vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = 8'h00;
`ifdef SORT_BATCH_CTRL_PAD_EN
  logic       s_last = 1'b0;
`endif
  logic [127:0] sort_in;
  logic [127:0] sort_out;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  sort_batch_ctrl #(.VALUE_BITS(8), .DEPTH(4), .LATENCY(10)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef SORT_BATCH_CTRL_PAD_EN
    .s_last(s_last),
`endif
    .sort_in(sort_in), .sort_out(sort_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic vec_t sort_vec(input vec_t v);
    vec_t r = v;
    logic [7:0] t;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 15 - i; j++)
        if (r[j] > r[j+1]) begin
          t = r[j]; r[j] = r[j+1]; r[j+1] = t;
        end
    return r;
  endfunction

  // Sorter stand-in: sort_out reflects sort_in after 10 clock edges.
  vec_t pipe [10];
  always @(posedge clk) begin
    pipe[0] <= sort_vec(sort_in);
    for (int k = 1; k < 10; k++) pipe[k] <= pipe[k-1];
  end
  assign sort_out = pipe[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0h expected none", m_data);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("m_data", {24'h0, m_data}, {24'h0, e[7:0]});
        chk("m_last", {31'h0, m_last}, {31'h0, e[8]});
      end
    end
  end

  // Expected stream: first n_push sorted values, last flag on slot n_valid-1.
  task automatic push_exp(input logic [7:0] vals[16], input int n_push, input int n_valid);
    vec_t v, s;
    for (int i = 0; i < 16; i++) v[i] = (i < n_valid) ? vals[i] : 8'hFF;
    s = sort_vec(v);
    for (int i = 0; i < n_push; i++) exp_q.push_back({(i == n_valid - 1), s[i]});
  endtask

  task automatic send_batch(input logic [7:0] vals[16], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      int t;
      bit hs;
      t = 0;
      hs = 1'b0;
      s_valid = 1'b1;
      s_data  = vals[i];
`ifdef SORT_BATCH_CTRL_PAD_EN
      s_last  = (i == n - 1) && (n < 16);
`endif
      while (!hs && t < 100) begin
        hs = s_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!hs) chk("s_handshake_timeout", 0, 1);
      s_valid = 1'b0;
`ifdef SORT_BATCH_CTRL_PAD_EN
      s_last  = 1'b0;
`endif
      if (gaps && i < n - 1) begin
        @(posedge clk); #1;
        if (i == n - 2) chk("busy_before_last_in", {31'h0, busy}, 0);
      end
    end
  endtask

  task automatic wait_mvalid();
    int t;
    t = 0;
    while (!m_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_m_valid", {31'h0, m_valid}, 1);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_idle", {31'h0, busy}, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v_rev[16];
    logic [7:0] v_perm[16];
    logic [7:0] v_rnd[16];
    logic [7:0] v_dup[16];
    int n;

    v_rev  = '{8'h0F,8'h0E,8'h0D,8'h0C,8'h0B,8'h0A,8'h09,8'h08,
               8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01,8'h00};
    v_perm = '{8'h07,8'h02,8'h0F,8'h00,8'h09,8'h0C,8'h04,8'h01,
               8'h0E,8'h06,8'h0B,8'h03,8'h08,8'h0D,8'h05,8'h0A};
    v_rnd  = '{8'h9A,8'h13,8'hE7,8'h42,8'h05,8'hC8,8'h77,8'h3D,
               8'hB1,8'h60,8'h2E,8'hF4,8'h88,8'h19,8'hD3,8'h56};
    v_dup  = '{8'hFF,8'h00,8'h00,8'hFF,8'hFF,8'hFF,8'h00,8'h00,
               8'h00,8'hFF,8'hFF,8'h00,8'hFF,8'h00,8'h00,8'hFF};

    // Reset state
    #2;
    chk("rst_s_ready", {31'h0, s_ready}, 1);
    chk("rst_m_valid", {31'h0, m_valid}, 0);
    chk("rst_m_last",  {31'h0, m_last}, 0);
    chk("rst_m_data",  {24'h0, m_data}, 0);
    chk("rst_busy",    {31'h0, busy}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Full batch, descending input, no backpressure
    push_exp(v_rev, 16, 16);
    send_batch(v_rev, 16, 1'b0);
    chk("busy_after_fill", {31'h0, busy}, 1);
    wait_idle(n);
    chk("busy_cycles", n, 27);

    // Backpressure at idx 3
    m_ready = 1'b0;
    push_exp(v_perm, 16, 16);
    send_batch(v_perm, 16, 1'b0);
    wait_mvalid();
    m_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    m_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_valid", {31'h0, m_valid}, 1);
      chk("bp_m_data",  {24'h0, m_data}, 32'h03);
      chk("bp_s_ready", {31'h0, s_ready}, 0);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    wait_idle(n);

    // Input gaps
    push_exp(v_rev, 16, 16);
    send_batch(v_rev, 16, 1'b1);
    chk("busy_after_last_in", {31'h0, busy}, 1);
    wait_idle(n);

    // Reset in the middle of DRAIN, at idx 7
    push_exp(v_perm, 7, 16);
    send_batch(v_perm, 16, 1'b0);
    wait_mvalid();
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mid_rst_m_valid", {31'h0, m_valid}, 0);
    chk("mid_rst_busy",    {31'h0, busy}, 0);
    chk("mid_rst_q_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_s_ready", {31'h0, s_ready}, 1);
    push_exp(v_rnd, 16, 16);
    send_batch(v_rnd, 16, 1'b0);
    wait_idle(n);

    // Duplicates and extremes
    push_exp(v_dup, 16, 16);
    send_batch(v_dup, 16, 1'b0);
    wait_idle(n);

`ifdef SORT_BATCH_CTRL_PAD_EN
    begin
      logic [7:0] v_pad[16];
      v_pad = '{8'h30,8'h10,8'h50,8'h20,8'h40,8'h00,8'h00,8'h00,
                8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
      push_exp(v_pad, 5, 5);
      send_batch(v_pad, 5, 1'b0);
      for (int i = 5; i < 16; i++) chk("pad_sort_in", {24'h0, sort_in[i*8 +: 8]}, 32'hFF);
      wait_idle(n);
    end
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("final_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
